// File: rtl/keyboard_pkg.sv
// ============================================================================
// Module : keyboard_pkg
// Purpose: Shared definitions for the PS/2 keyboard tracker: scan-code set 2
//          constants for the ten game keys and the two prefix bytes, the key
//          index enumeration used to address the held-bit vector, the frame
//          timeout length and the scan-code to key decode helper.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package keyboard_pkg;

  // Scan-code set 2 make codes (break = F0 prefix + make code)
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  // Idle CLOCK_50 cycles after which a partial frame is abandoned (~2.6 ms)
  localparam int TIMEOUT_CYCLES = 131072;

  localparam int NUM_KEYS = 10;

  // Bit position of each key in the held / output vectors
  typedef enum logic [3:0] {
    KEY_W     = 4'd0,
    KEY_A     = 4'd1,
    KEY_S     = 4'd2,
    KEY_D     = 4'd3,
    KEY_LEFT  = 4'd4,
    KEY_RIGHT = 4'd5,
    KEY_UP    = 4'd6,
    KEY_DOWN  = 4'd7,
    KEY_SPACE = 4'd8,
    KEY_ENTER = 4'd9
  } key_idx_e;

  typedef struct packed {
    logic     hit;
    key_idx_e idx;
  } key_hit_t;

  // Map a received make code to a key. The E0 prefix selects a different
  // table: arrows only exist extended, letters/space only non-extended, and
  // Enter exists in both (main and keypad Enter behave identically).
  function automatic key_hit_t decode_key(input logic ext, input logic [7:0] code);
    key_hit_t r;
    r.hit = 1'b1;
    r.idx = KEY_W;
    if (!ext) begin
      case (code)
        SC_W:     r.idx = KEY_W;
        SC_A:     r.idx = KEY_A;
        SC_S:     r.idx = KEY_S;
        SC_D:     r.idx = KEY_D;
        SC_SPACE: r.idx = KEY_SPACE;
        SC_ENTER: r.idx = KEY_ENTER;
        default:  r.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_LEFT:  r.idx = KEY_LEFT;
        SC_RIGHT: r.idx = KEY_RIGHT;
        SC_UP:    r.idx = KEY_UP;
        SC_DOWN:  r.idx = KEY_DOWN;
        SC_ENTER: r.idx = KEY_ENTER;
        default:  r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/keyboard_tracker_if.sv
// ============================================================================
// Module : keyboard_tracker_if
// Purpose: Received-byte bus between the PS/2 receiver and the key decoder.
// Ports  : data  - 8-bit byte received from the keyboard
//          valid - one-cycle strobe, data is meaningful only while high
//          master modport: receiver side, slave modport: decoder side
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface keyboard_tracker_if;
  logic [7:0] data;
  logic       valid;

  modport master (output data, output valid);
  modport slave  (input  data, input  valid);
endinterface

`default_nettype wire

// File: rtl/keyboard_tracker_ps2_rx.sv
// ============================================================================
// Module : ps2_rx
// Purpose: Receive-only PS/2 byte receiver. Synchronizes PS2_CLK/PS2_DAT,
//          samples data on each falling edge of the synchronized clock,
//          assembles 11-bit frames, checks start/odd-parity/stop and emits
//          good bytes. A partial frame is dropped after TIMEOUT_LEN idle
//          cycles.
// Ports  : clk     - system clock
//          resetn  - synchronous active-low reset
//          ps2_clk - raw PS/2 clock pin level
//          ps2_dat - raw PS/2 data pin level
//          rx      - received-byte bus (master)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_rx #(
  parameter int TIMEOUT_LEN = keyboard_pkg::TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ps2_clk,
  input  logic               ps2_dat,
  keyboard_tracker_if.master rx
);

  localparam int TW = $clog2(TIMEOUT_LEN);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_prev;
  logic          fall;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [TW-1:0] idle_cnt;
  logic [7:0]    data_r;
  logic          valid_r;

  // Two-flop synchronizers, idle level is high
  always_ff @(posedge clk) begin
    if (!resetn) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall = clk_prev & ~clk_sync[1];

  // Frame assembly. Bits shift in from the top, so once ten bits are in,
  // shreg[0] is the start bit, shreg[8:1] the data byte and shreg[9] parity;
  // the eleventh (stop) bit is judged straight from the synchronizer.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bit_cnt  <= 4'd0;
      shreg    <= 10'd0;
      idle_cnt <= '0;
      data_r   <= 8'd0;
      valid_r  <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          data_r  <= shreg[8:1];
          valid_r <= ~shreg[0] & dat_sync[1] & (^shreg[9:1]);
        end else begin
          shreg   <= {dat_sync[1], shreg[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (idle_cnt == TW'(TIMEOUT_LEN - 1)) begin
          bit_cnt  <= 4'd0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  assign rx.data  = data_r;
  assign rx.valid = valid_r;

endmodule

`default_nettype wire

// File: rtl/keyboard_tracker.sv
// ============================================================================
// Module : keyboard_tracker
// Purpose: PS/2 keyboard front end producing per-key state for W/A/S/D, the
//          four arrows, Space and Enter. Tracks the E0/F0 prefixes, keeps a
//          held bit per key and presents either held levels or one-cycle
//          press pulses. Never drives the PS/2 lines.
// Ports  : CLOCK_50        - 50 MHz system clock
//          resetn          - synchronous active-low reset
//          PS2_CLK/PS2_DAT - PS/2 lines, permanently high-Z from this side
//          w,a,s,d,left,right,up,down,space,enter - key outputs
//          PULSE_OR_HOLD   - 0 held level, 1 single-cycle press pulse
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module keyboard_tracker
  import keyboard_pkg::*;
#(
  parameter bit PULSE_OR_HOLD = 1'b0,
  parameter int TIMEOUT_LEN   = keyboard_pkg::TIMEOUT_CYCLES
) (
  input  wire  CLOCK_50,
  input  wire  resetn,
  inout  wire  PS2_CLK,
  inout  wire  PS2_DAT,
  output logic w,
  output logic a,
  output logic s,
  output logic d,
  output logic left,
  output logic right,
  output logic up,
  output logic down,
  output logic space,
  output logic enter
);

  assign PS2_CLK = 1'bz;
  assign PS2_DAT = 1'bz;

  keyboard_tracker_if rx_bus ();

  ps2_rx #(.TIMEOUT_LEN(TIMEOUT_LEN)) u_rx (
    .clk     (CLOCK_50),
    .resetn  (resetn),
    .ps2_clk (PS2_CLK),
    .ps2_dat (PS2_DAT),
    .rx      (rx_bus)
  );

  logic                ext;
  logic                brk;
  logic [NUM_KEYS-1:0] held;
  logic                ext_nxt;
  logic                brk_nxt;
  logic [NUM_KEYS-1:0] held_nxt;
  logic [NUM_KEYS-1:0] out_vec;
  key_hit_t            hit;

  // Prefixes are sticky until the next non-prefix byte, mapped or not.
  always_comb begin
    ext_nxt  = ext;
    brk_nxt  = brk;
    held_nxt = held;
    hit      = decode_key(ext, rx_bus.data);
    if (rx_bus.valid) begin
      if (rx_bus.data == SC_EXT) begin
        ext_nxt = 1'b1;
      end else if (rx_bus.data == SC_BRK) begin
        brk_nxt = 1'b1;
      end else begin
        ext_nxt = 1'b0;
        brk_nxt = 1'b0;
        if (hit.hit) begin
          held_nxt[hit.idx] = ~brk;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      ext  <= 1'b0;
      brk  <= 1'b0;
      held <= '0;
    end else begin
      ext  <= ext_nxt;
      brk  <= brk_nxt;
      held <= held_nxt;
    end
  end

  generate
    if (PULSE_OR_HOLD) begin : g_pulse
      logic [NUM_KEYS-1:0] pulse;
      // Registered alongside held so the pulse lands on the same edge the
      // held bit rises; a repeat make leaves held unchanged, hence no pulse.
      always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
          pulse <= '0;
        end else begin
          pulse <= held_nxt & ~held;
        end
      end
      assign out_vec = pulse;
    end else begin : g_hold
      assign out_vec = held;
    end
  endgenerate

  assign w     = out_vec[KEY_W];
  assign a     = out_vec[KEY_A];
  assign s     = out_vec[KEY_S];
  assign d     = out_vec[KEY_D];
  assign left  = out_vec[KEY_LEFT];
  assign right = out_vec[KEY_RIGHT];
  assign up    = out_vec[KEY_UP];
  assign down  = out_vec[KEY_DOWN];
  assign space = out_vec[KEY_SPACE];
  assign enter = out_vec[KEY_ENTER];

endmodule

`default_nettype wire

// File: tb/tb_keyboard_tracker.sv
// ============================================================================
// Module : tb_keyboard_tracker
// Purpose: Directed self-checking bench for keyboard_tracker. One instance in
//          hold mode, one in pulse mode and a standalone receiver on the same
//          PS/2 lines, all driven by a bit-level PS/2 frame generator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_keyboard_tracker;

  localparam int HALF = 6;    // CLOCK_50 cycles per PS/2 clock level
  localparam int GAP  = 20;   // idle cycles between frames
  localparam int TO   = 512;  // shortened frame timeout

  localparam logic [9:0] K_W     = 10'h001;
  localparam logic [9:0] K_A     = 10'h002;
  localparam logic [9:0] K_S     = 10'h004;
  localparam logic [9:0] K_LEFT  = 10'h010;
  localparam logic [9:0] K_UP    = 10'h040;
  localparam logic [9:0] K_SPACE = 10'h100;
  localparam logic [9:0] K_ENTER = 10'h200;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic ps2_clk_drv = 1'b1;
  logic ps2_dat_drv = 1'b1;
  wire  ps2_clk_w;
  wire  ps2_dat_w;
  assign ps2_clk_w = ps2_clk_drv;
  assign ps2_dat_w = ps2_dat_drv;

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic w_h, a_h, s_h, d_h, l_h, r_h, u_h, dn_h, sp_h, en_h;
  logic w_p, a_p, s_p, d_p, l_p, r_p, u_p, dn_p, sp_p, en_p;
  logic [9:0] keys_h;
  logic [9:0] keys_p;
  assign keys_h = {en_h, sp_h, dn_h, u_h, r_h, l_h, d_h, s_h, a_h, w_h};
  assign keys_p = {en_p, sp_p, dn_p, u_p, r_p, l_p, d_p, s_p, a_p, w_p};

  keyboard_tracker #(.PULSE_OR_HOLD(1'b0), .TIMEOUT_LEN(TO)) u_hold (
    .CLOCK_50(clk), .resetn(resetn), .PS2_CLK(ps2_clk_w), .PS2_DAT(ps2_dat_w),
    .w(w_h), .a(a_h), .s(s_h), .d(d_h), .left(l_h), .right(r_h),
    .up(u_h), .down(dn_h), .space(sp_h), .enter(en_h)
  );

  keyboard_tracker #(.PULSE_OR_HOLD(1'b1), .TIMEOUT_LEN(TO)) u_pulse (
    .CLOCK_50(clk), .resetn(resetn), .PS2_CLK(ps2_clk_w), .PS2_DAT(ps2_dat_w),
    .w(w_p), .a(a_p), .s(s_p), .d(d_p), .left(l_p), .right(r_p),
    .up(u_p), .down(dn_p), .space(sp_p), .enter(en_p)
  );

  keyboard_tracker_if mon_bus ();

  ps2_rx #(.TIMEOUT_LEN(TO)) u_mon (
    .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk_w), .ps2_dat(ps2_dat_w),
    .rx(mon_bus)
  );

  // Negedge monitors: received bytes and pulse-mode Enter activity
  int         byte_cnt = 0;
  logic [7:0] last_byte = 8'h00;
  int         enter_pulses = 0;
  logic       enter_prev = 1'b0;
  logic       pulse_long = 1'b0;
  logic       other_pulse = 1'b0;

  always @(negedge clk) begin
    if (mon_bus.valid) begin
      byte_cnt  = byte_cnt + 1;
      last_byte = mon_bus.data;
    end
    if (en_p) begin
      enter_pulses = enter_pulses + 1;
      if (enter_prev) pulse_long = 1'b1;
    end
    if (keys_p[8:0] != 9'd0) other_pulse = 1'b1;
    enter_prev = en_p;
  end

  function automatic logic [10:0] frame(input logic [7:0] b);
    return {1'b1, ~(^b), b, 1'b0};
  endfunction

  // Drive nbits of a frame LSB first. With hold_low the task returns right
  // after the last falling edge (line still low); finish_frame completes it.
  task automatic send_bits(input logic [10:0] f, input int nbits, input bit hold_low);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_dat_drv = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk_drv = 1'b0;
      if (hold_low && i == nbits - 1) return;
      repeat (HALF) @(negedge clk);
      ps2_clk_drv = 1'b1;
    end
    repeat (HALF) @(negedge clk);
    ps2_dat_drv = 1'b1;
  endtask

  task automatic finish_frame();
    repeat (HALF) @(negedge clk);
    ps2_clk_drv = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_dat_drv = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(frame(b), 11, 1'b0);
    repeat (GAP) @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (keys_h !== 10'd0) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=%h", keys_h, 10'd0);
    end
    checks++;
    if (keys_p !== 10'd0) begin
      failures++;
      $display("FAIL reset_pulse got=%h exp=%h", keys_p, 10'd0);
    end
    resetn = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_hold();
    send_bits(frame(8'h1D), 11, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (keys_h !== 10'd0) begin
      failures++;
      $display("FAIL hold_make_early got=%h exp=%h", keys_h, 10'd0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (keys_h !== K_W) begin
      failures++;
      $display("FAIL hold_make_edge4 got=%h exp=%h", keys_h, K_W);
    end
    finish_frame();
    repeat (50) @(negedge clk);
    checks++;
    if (keys_h !== K_W) begin
      failures++;
      $display("FAIL hold_stays got=%h exp=%h", keys_h, K_W);
    end
    send_byte(8'hF0);
    checks++;
    if (keys_h !== K_W) begin
      failures++;
      $display("FAIL hold_after_f0 got=%h exp=%h", keys_h, K_W);
    end
    send_bits(frame(8'h1D), 11, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (keys_h !== K_W) begin
      failures++;
      $display("FAIL hold_break_early got=%h exp=%h", keys_h, K_W);
    end
    @(posedge clk);
    #1;
    checks++;
    if (keys_h !== 10'd0) begin
      failures++;
      $display("FAIL hold_break_edge4 got=%h exp=%h", keys_h, 10'd0);
    end
    finish_frame();
  endtask

  task automatic test_extended();
    send_byte(8'hE0);
    send_byte(8'h6B);
    checks++;
    if (keys_h !== K_LEFT) begin
      failures++;
      $display("FAIL ext_left_make got=%h exp=%h", keys_h, K_LEFT);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);
    checks++;
    if (keys_h !== 10'd0) begin
      failures++;
      $display("FAIL ext_left_break got=%h exp=%h", keys_h, 10'd0);
    end
    send_byte(8'h6B);
    checks++;
    if (keys_h !== 10'd0) begin
      failures++;
      $display("FAIL plain_6b_ignored got=%h exp=%h", keys_h, 10'd0);
    end
    send_byte(8'hE0);
    send_byte(8'h1D);
    checks++;
    if (keys_h !== 10'd0) begin
      failures++;
      $display("FAIL ext_1d_ignored got=%h exp=%h", keys_h, 10'd0);
    end
    // ext must have been cleared by the ignored E0 1D
    send_byte(8'h1D);
    checks++;
    if (keys_h !== K_W) begin
      failures++;
      $display("FAIL ext_cleared got=%h exp=%h", keys_h, K_W);
    end
    send_byte(8'hF0);
    send_byte(8'h1D);
  endtask

  task automatic test_pulse();
    enter_pulses = 0;
    pulse_long   = 1'b0;
    other_pulse  = 1'b0;
    send_byte(8'h5A);
    checks++;
    if (enter_pulses !== 1) begin
      failures++;
      $display("FAIL pulse_first got=%0d exp=%0d", enter_pulses, 1);
    end
    send_byte(8'h5A);
    send_byte(8'h5A);
    checks++;
    if (enter_pulses !== 1) begin
      failures++;
      $display("FAIL pulse_repeat got=%0d exp=%0d", enter_pulses, 1);
    end
    checks++;
    if (keys_h !== K_ENTER) begin
      failures++;
      $display("FAIL hold_enter got=%h exp=%h", keys_h, K_ENTER);
    end
    send_byte(8'hF0);
    send_byte(8'h5A);
    checks++;
    if (enter_pulses !== 1 || keys_h !== 10'd0) begin
      failures++;
      $display("FAIL pulse_release got=%0d/%h exp=%0d/%h", enter_pulses, keys_h, 1, 10'd0);
    end
    send_bits(frame(8'h5A), 11, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (en_p !== 1'b0) begin
      failures++;
      $display("FAIL pulse_early got=%b exp=%b", en_p, 1'b0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (en_p !== 1'b1) begin
      failures++;
      $display("FAIL pulse_edge4 got=%b exp=%b", en_p, 1'b1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (en_p !== 1'b0) begin
      failures++;
      $display("FAIL pulse_width got=%b exp=%b", en_p, 1'b0);
    end
    finish_frame();
    checks++;
    if (enter_pulses !== 2 || pulse_long !== 1'b0 || other_pulse !== 1'b0) begin
      failures++;
      $display("FAIL pulse_total got=%0d long=%b other=%b exp=2 long=0 other=0",
               enter_pulses, pulse_long, other_pulse);
    end
    // keypad Enter shares the held bit
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h5A);
    checks++;
    if (keys_h !== 10'd0) begin
      failures++;
      $display("FAIL keypad_enter_break got=%h exp=%h", keys_h, 10'd0);
    end
  endtask

  task automatic test_errors();
    int snap;
    snap = byte_cnt;
    send_bits({1'b1, ^(8'h1D), 8'h1D, 1'b0}, 11, 1'b0);
    repeat (GAP) @(negedge clk);
    send_bits({1'b0, ~(^(8'h1D)), 8'h1D, 1'b0}, 11, 1'b0);
    repeat (GAP) @(negedge clk);
    checks++;
    if (keys_h !== 10'd0 || byte_cnt !== snap) begin
      failures++;
      $display("FAIL bad_frames got=%h/%0d exp=%h/%0d", keys_h, byte_cnt, 10'd0, snap);
    end
    send_byte(8'h1C);
    checks++;
    if (keys_h !== K_A || last_byte !== 8'h1C || byte_cnt !== snap + 1) begin
      failures++;
      $display("FAIL good_after_bad got=%h/%h/%0d exp=%h/1c/%0d",
               keys_h, last_byte, byte_cnt, K_A, snap + 1);
    end
    send_byte(8'hF0);
    send_byte(8'h1C);
  endtask

  task automatic test_timeout_reset();
    send_bits(frame(8'h1D), 5, 1'b0);
    repeat (TO + 200) @(negedge clk);
    send_byte(8'h29);
    checks++;
    if (keys_h !== K_SPACE) begin
      failures++;
      $display("FAIL timeout_resync got=%h exp=%h", keys_h, K_SPACE);
    end
    send_bits(frame(8'h1B), 3, 1'b0);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (keys_h !== 10'd0 || keys_p !== 10'd0) begin
      failures++;
      $display("FAIL midframe_reset got=%h/%h exp=0/0", keys_h, keys_p);
    end
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    send_byte(8'h1B);
    checks++;
    if (keys_h !== K_S) begin
      failures++;
      $display("FAIL after_reset got=%h exp=%h", keys_h, K_S);
    end
    send_byte(8'hF0);
    send_byte(8'h1B);
  endtask

  task automatic test_concurrency();
    send_byte(8'h1D);
    send_byte(8'hE0);
    send_byte(8'h75);
    send_byte(8'h29);
    checks++;
    if (keys_h !== (K_W | K_UP | K_SPACE)) begin
      failures++;
      $display("FAIL concurrent_make got=%h exp=%h", keys_h, K_W | K_UP | K_SPACE);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    checks++;
    if (keys_h !== (K_W | K_SPACE)) begin
      failures++;
      $display("FAIL concurrent_break_up got=%h exp=%h", keys_h, K_W | K_SPACE);
    end
  endtask

  task automatic test_back_to_back();
    send_bits(frame(8'hF0), 11, 1'b0);
    send_bits(frame(8'h1D), 11, 1'b0);
    send_bits(frame(8'hF0), 11, 1'b0);
    send_bits(frame(8'h29), 11, 1'b0);
    repeat (GAP) @(negedge clk);
    checks++;
    if (keys_h !== 10'd0) begin
      failures++;
      $display("FAIL back_to_back got=%h exp=%h", keys_h, 10'd0);
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_extended();
    test_pulse();
    test_errors();
    test_timeout_reset();
    test_concurrency();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/keyboard_tracker.md
# keyboard_tracker

PS/2 keyboard front end that turns the raw PS2_CLK/PS2_DAT stream (scan-code set 2) into per-key state flags for the ten keys the game uses: W, A, S, D, the four arrows, Space and Enter. It sits between the board's PS/2 pins and the gomoku control logic, which consumes either held levels or single-cycle press pulses. The block is receive-only and never drives the PS/2 lines.

## Interface
- PULSE_OR_HOLD, default 0: 0 = hold mode (output high while key is down); 1 = pulse mode (one-cycle pulse per fresh press).
- CLOCK_50  input  1  system clock, 50 MHz.
- resetn  input  1  reset resetn, synchronous, active-low; clock CLOCK_50.
- PS2_CLK  inout  1  PS/2 clock from keyboard; driven high-Z permanently.
- PS2_DAT  inout  1  PS/2 data from keyboard; driven high-Z permanently.
- w, a, s, d  output  1 each  letter key state.
- left, right, up, down  output  1 each  arrow key state.
- space, enter  output  1 each  Space / Enter state.

## Operation
- PS2_CLK and PS2_DAT each pass through a 2-flop synchronizer; a falling edge of synchronized PS2_CLK samples synchronized PS2_DAT.
- Frame: 11 bits — start 0, 8 data LSB first, odd parity, stop 1. Byte accepted only if start=0, parity odd over data+parity, stop=1; otherwise discarded silently.
- Frame timeout: if 2^17 CLOCK_50 cycles (~2.6 ms) pass with no falling edge while the bit counter is non-zero, the partial frame is dropped and the counter returns to 0.
- Decoder keeps two sticky flags: ext (set by E0) and brk (set by F0). Both clear after any non-prefix byte, whether or not that byte is mapped.
- Mapping (non-extended): 1D=w, 1C=a, 1B=s, 23=d, 29=space, 5A=enter. Extended (E0 prefix): 6B=left, 74=right, 75=up, 72=down, 5A=enter (keypad Enter). Non-extended 6B/74/75/72 (keypad digits) and extended 1D/1C/1B/23/29 are ignored.
- Make (brk=0) sets the key's held bit; break (brk=1) clears it. Unmapped codes change nothing.
- Hold mode: each output equals its held bit. Pulse mode: output high for exactly one cycle when the held bit goes 0->1; typematic repeat makes while already held produce no further pulse.
- Keys are independent; any combination may be held simultaneously.

## Timing
- Reset: all ten outputs 0, held bits 0, ext/brk 0, bit counter 0, timeout counter 0, synchronizers to 1 (idle). Reset mid-frame discards the partial frame.
- Latency: output update occurs on the 4th CLOCK_50 rising edge after the PS2_CLK falling edge of the stop bit arrives at the pin (2 sync, 1 shift/validate, 1 decode/output register).
- Pulse width in pulse mode: exactly 1 cycle.
- PS/2 clock 10–16.7 kHz is far below CLOCK_50; no bit is missed provided each PS2_CLK level lasts >3 cycles.

## Structure
- Package keyboard_pkg: scan-code constants (SC_W, SC_A, SC_S, SC_D, SC_SPACE, SC_ENTER, SC_LEFT, SC_RIGHT, SC_UP, SC_DOWN, SC_EXT=E0, SC_BRK=F0), key index enum (10 entries), TIMEOUT_CYCLES.
- Sub-module ps2_rx: synchronizers, edge detect, shift register, parity/framing check, timeout; outputs 8-bit byte plus 1-cycle byte_valid. Top holds prefix flags, held-bit vector and pulse logic.

## Test plan
- Hold mode: send 1D, then F0 1D -> w rises 4 cycles after stop edge of 1D, stays 1, falls after stop edge of second 1D; other outputs remain 0.
- Extended: send E0 6B, E0 F0 6B; also plain 6B -> left goes 1 then 0; plain 6B changes nothing.
- Pulse mode: send 5A, 5A, 5A, F0 5A, 5A -> enter pulses once (1 cycle) for first make, none for repeats, once more after release.
- Error handling: frame 1D with bad parity, then frame with stop=0 -> no output change; next good 1C sets a.
- Timeout/reset: send 5 bits, idle 3 ms, then full 29 -> space=1; assert resetn=0 mid-frame and while space held -> all outputs 0, next clean frame decodes correctly.
- Concurrency: make 1D, E0 75, 29, then break E0 75 -> w=1, up 1->0, space=1 independently.
